demux_1_to_2_buf: RTL

- Inverse of the datapath 2-to-1 mux: routes one 32-bit producer stream to one of two consumer channels, selected per transfer by `Sel`.
- Each output channel has its own small FIFO, so a stalled consumer never blocks transfers to the other channel.
- Used between execute-stage results and two independent sinks (e.g. write-back path and HI/LO or debug capture).

---
 rtl/demux_1_to_2_buf_pkg.sv | 16 +
 rtl/demux_1_to_2_buf_if.sv | 38 +++
 rtl/demux_1_to_2_buf_sync_fifo_ch.sv | 60 ++++++
 rtl/demux_1_to_2_buf.sv | 86 ++++++++
 4 files changed

// File: rtl/demux_1_to_2_buf_pkg.sv
// Shared constants for the 1-to-2 buffered demux: channel indices, default
// sizes and the occupancy-counter width helper.
package demux_pkg;

  localparam int CH0 = 0;
  localparam int CH1 = 1;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 2;

  // One extra bit so a full FIFO (count == DEPTH) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/demux_1_to_2_buf_if.sv
// Producer stream plus two consumer channels of the 1-to-2 demux.
// slave = the demux side, master = the producer/consumer side.
interface demux_1_to_2_buf_if #(
  parameter int WIDTH = demux_pkg::DEF_WIDTH
);

  logic [WIDTH-1:0] In_Data;
  logic             In_Sel;
  logic             In_Valid;
  logic             In_Ready;

  logic [WIDTH-1:0] Out0_Data;
  logic             Out0_Valid;
  logic             Out0_Ready;

  logic [WIDTH-1:0] Out1_Data;
  logic             Out1_Valid;
  logic             Out1_Ready;

  modport slave (
    input  In_Data, In_Sel, In_Valid,
    output In_Ready,
    output Out0_Data, Out0_Valid,
    input  Out0_Ready,
    output Out1_Data, Out1_Valid,
    input  Out1_Ready
  );

  modport master (
    output In_Data, In_Sel, In_Valid,
    input  In_Ready,
    input  Out0_Data, Out0_Valid,
    output Out0_Ready,
    input  Out1_Data, Out1_Valid,
    output Out1_Ready
  );

endinterface

// File: rtl/demux_1_to_2_buf_sync_fifo_ch.sv
// Single-clock per-channel FIFO: head is registered state (1-cycle latency),
// push ignored when full, pop ignored when empty; head reads 0 while empty.
module sync_fifo_ch
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~w_empty;

  assign o_count = r_count;
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so wrap is the natural overflow.
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/demux_1_to_2_buf.sv
// Routes one stream to two independently buffered channels; 1-cycle latency,
// In_Ready = !full[In_Sel]. DEMUX_BYPASS_EN adds 0-latency empty-channel bypass.
module demux_1_to_2_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic               Clk,
  input logic               Reset,
  demux_1_to_2_buf_if.slave bus
);

  localparam int CNT_W = cnt_width(DEPTH);

  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic [1:0]       w_full;
  logic [1:0]       w_byp;
  logic [1:0]       w_nonempty;
  logic [WIDTH-1:0] w_head  [2];
  logic [CNT_W-1:0] w_count [2];
  logic             w_accept;

  // Ready looks only at the selected channel's registered count, never at OutN_Ready.
  assign bus.In_Ready = ~w_full[bus.In_Sel];
  assign w_accept     = bus.In_Valid & bus.In_Ready;

  assign w_nonempty[CH0] = (w_count[CH0] != '0);
  assign w_nonempty[CH1] = (w_count[CH1] != '0);

`ifdef DEMUX_BYPASS_EN
  assign w_byp[CH0] = w_accept & ~bus.In_Sel & ~w_nonempty[CH0] & bus.Out0_Ready;
  assign w_byp[CH1] = w_accept &  bus.In_Sel & ~w_nonempty[CH1] & bus.Out1_Ready;

  assign bus.Out0_Valid = w_nonempty[CH0] | w_byp[CH0];
  assign bus.Out0_Data  = w_byp[CH0] ? bus.In_Data : w_head[CH0];
  assign bus.Out1_Valid = w_nonempty[CH1] | w_byp[CH1];
  assign bus.Out1_Data  = w_byp[CH1] ? bus.In_Data : w_head[CH1];
`else
  assign w_byp = 2'b00;

  assign bus.Out0_Valid = w_nonempty[CH0];
  assign bus.Out0_Data  = w_head[CH0];
  assign bus.Out1_Valid = w_nonempty[CH1];
  assign bus.Out1_Data  = w_head[CH1];
`endif

  // A bypassed word is consumed directly and never written into storage.
  assign w_push[CH0] = w_accept & ~bus.In_Sel & ~w_byp[CH0];
  assign w_push[CH1] = w_accept &  bus.In_Sel & ~w_byp[CH1];

  assign w_pop[CH0] = bus.Out0_Ready;
  assign w_pop[CH1] = bus.Out1_Ready;

  sync_fifo_ch #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_ch0 (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_push  (w_push[CH0]),
    .i_data  (bus.In_Data),
    .i_pop   (w_pop[CH0]),
    .o_data  (w_head[CH0]),
    .o_full  (w_full[CH0]),
    .o_count (w_count[CH0])
  );

  sync_fifo_ch #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_ch1 (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_push  (w_push[CH1]),
    .i_data  (bus.In_Data),
    .i_pop   (w_pop[CH1]),
    .o_data  (w_head[CH1]),
    .o_full  (w_full[CH1]),
    .o_count (w_count[CH1])
  );

endmodule
